id_issue_reader: RTL and testbench

//  Read side of the decode instruction queue: pops 96-bit decoded entries, holds one in an issue register,

---
 rtl/id_issue_pkg.sv | 36 +++
 rtl/id_issue_if.sv | 38 +++
 rtl/issue_scoreboard.sv | 49 ++++
 rtl/id_issue_reader.sv | 97 +++++++++
 tb/tb_id_issue_reader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_issue_pkg.sv
// Shared types for the decode-queue issue reader: entry layout, register file sizing, FSM states.
package id_issue_pkg;

    localparam int unsigned FIFO_ENTRY_SIZE = 96;
    localparam int unsigned NUM_REGS        = 32;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned STAT_W          = 32;

    localparam int unsigned INSTR_LSB = 0;
    localparam int unsigned PC_LSB    = 32;
    localparam int unsigned DST_LSB   = 64;
    localparam int unsigned SRC1_LSB  = 69;
    localparam int unsigned SRC2_LSB  = 74;
    localparam int unsigned FLAGS_LSB = 79;
    localparam int unsigned CTRL_LSB  = 82;
    localparam int unsigned CTRL_W    = FIFO_ENTRY_SIZE - CTRL_LSB;

    // Declared MSB first so the packed layout matches the queue entry bit positions.
    typedef struct packed {
        logic [CTRL_W-1:0]              ctrl;
        logic                           use_s2;
        logic                           use_s1;
        logic                           wr_en;
        logic [FLAGS_LSB-SRC2_LSB-1:0]  src2;
        logic [SRC2_LSB-SRC1_LSB-1:0]   src1;
        logic [SRC1_LSB-DST_LSB-1:0]    dst;
        logic [DST_LSB-PC_LSB-1:0]      pc;
        logic [PC_LSB-INSTR_LSB-1:0]    instr;
    } entry_t;

    typedef enum logic {
        StIdle,
        StHeld
    } state_e;

endpackage

// File: rtl/id_issue_if.sv
// Queue, execute and writeback signals of the issue reader; stat ports exist only with
// ID_ISSUE_STATS_EN defined.
interface id_issue_if;
    import id_issue_pkg::*;

    logic                       FREEZE;
    logic                       mispredict;
    logic                       flush_fCOM;
    logic                       empty_FIFO;
    logic [FIFO_ENTRY_SIZE-1:0] data_out;
    logic                       do_read;
    logic                       ex_valid;
    logic                       ex_ready;
    logic [FIFO_ENTRY_SIZE-1:0] ex_data;
    logic                       wb_valid;
    logic [REG_ADDR_W-1:0]      wb_reg;
`ifdef ID_ISSUE_STATS_EN
    logic [STAT_W-1:0]          stat_issued;
    logic [STAT_W-1:0]          stat_stalls;
`endif

    modport master (
        input  FREEZE, mispredict, flush_fCOM, empty_FIFO, data_out, ex_ready, wb_valid, wb_reg,
`ifdef ID_ISSUE_STATS_EN
        output stat_issued, stat_stalls,
`endif
        output do_read, ex_valid, ex_data
    );

    modport slave (
        output FREEZE, mispredict, flush_fCOM, empty_FIFO, data_out, ex_ready, wb_valid, wb_reg,
`ifdef ID_ISSUE_STATS_EN
        input  stat_issued, stat_stalls,
`endif
        input  do_read, ex_valid, ex_data
    );

endinterface

// File: rtl/issue_scoreboard.sv
// Register busy scoreboard: one set and one clear per edge (set wins), three lookups that see
// this cycle's writeback clear already applied. r0 is never busy.
module issue_scoreboard
    import id_issue_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        set_en,
    input  logic [REG_ADDR_W-1:0]       set_idx,
    input  logic                        clr_en,
    input  logic [REG_ADDR_W-1:0]       clr_idx,
    input  logic [2:0][REG_ADDR_W-1:0]  look_idx,
    output logic [2:0]                  look_busy
);

    logic [NUM_REGS-1:0] busy_q, busy_d, clr_mask, busy_byp;

    always_comb begin
        clr_mask = '0;
        if (clr_en) begin
            clr_mask[clr_idx] = 1'b1;
        end
    end

    assign busy_byp = busy_q & ~clr_mask;

    always_comb begin
        busy_d = busy_byp;
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            look_busy[i] = (look_idx[i] != '0) && busy_byp[look_idx[i]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/id_issue_reader.sv
// Read side of the decode queue: issue register, RAW/WAW hazard check, valid/ready dispatch.
// Optional issue/stall counters with ID_ISSUE_STATS_EN defined.
module id_issue_reader
    import id_issue_pkg::*;
(
    input logic        CLK,
    input logic        RESET,
    id_issue_if.master bus
);

    state_e                     state_q, state_d;
    entry_t                     held_q;
    logic                       hold_valid;
    logic                       flush;
    logic                       hazard;
    logic                       fire;
    logic                       pop;
    logic                       sb_set;
    logic [2:0][REG_ADDR_W-1:0] look_idx;
    logic [2:0]                 look_busy;

    assign hold_valid = (state_q == StHeld);
    assign flush      = bus.mispredict | bus.flush_fCOM;

    assign look_idx = {held_q.dst, held_q.src2, held_q.src1};
    assign hazard   = (held_q.use_s1 & look_busy[0]) |
                      (held_q.use_s2 & look_busy[1]) |
                      (held_q.wr_en  & look_busy[2]);

    assign bus.ex_valid = hold_valid & ~hazard & ~bus.FREEZE & ~flush;
    assign bus.ex_data  = held_q;
    assign fire         = bus.ex_valid & bus.ex_ready;
    assign sb_set       = fire & held_q.wr_en & (held_q.dst != '0);

    issue_scoreboard u_scoreboard (
        .clk       (CLK),
        .rst       (RESET),
        .set_en    (sb_set),
        .set_idx   (held_q.dst),
        .clr_en    (bus.wb_valid),
        .clr_idx   (bus.wb_reg),
        .look_idx  (look_idx),
        .look_busy (look_busy)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (!RESET && !bus.FREEZE && !flush) begin
            unique case (state_q)
                StIdle: pop = ~bus.empty_FIFO;
                StHeld: pop = fire & ~bus.empty_FIFO;
            endcase
        end
        // Flush discards the held entry even while frozen.
        if (flush) begin
            state_d = StIdle;
        end else if (!bus.FREEZE) begin
            unique case (state_q)
                StIdle: if (pop) state_d = StHeld;
                StHeld: if (fire && !pop) state_d = StIdle;
            endcase
        end
    end

    assign bus.do_read = pop;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                held_q <= bus.data_out;
            end
        end
    end

`ifdef ID_ISSUE_STATS_EN
    logic [STAT_W-1:0] issued_q, stalls_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else begin
            issued_q <= issued_q + STAT_W'(fire);
            stalls_q <= stalls_q + STAT_W'(hold_valid & ~fire & ~bus.FREEZE);
        end
    end

    assign bus.stat_issued = issued_q;
    assign bus.stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_id_issue_reader.sv
// Bench for id_issue_reader: directed vector table, mid-operation reset, randomized traffic
// against a transaction-level reference model.
module tb_id_issue_reader;
    import id_issue_pkg::*;

    typedef struct {
        bit          empty;
        logic [95:0] data;
        bit          ready, frz, misp, flc, wbv;
        logic [4:0]  wbr;
    } in_t;

    typedef struct {
        in_t in;
        bit  e_rd, e_val;
    } vec_t;

    logic CLK, RESET;
    id_issue_if bus();

    id_issue_reader dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          tag    = 0;
    bit          m_hold;
    logic [95:0] m_data;
    bit          m_busy [NUM_REGS];
    bit   [31:0] m_issued, m_stalls;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [95:0] mk(int dst, int s1, int s2, bit wr, bit u1, bit u2);
        entry_t e;
        tag++;
        e        = '0;
        e.instr  = 32'hA000_0000 + 32'(tag);
        e.pc     = 32'(tag * 4);
        e.dst    = dst[4:0];
        e.src1   = s1[4:0];
        e.src2   = s2[4:0];
        e.wr_en  = wr;
        e.use_s1 = u1;
        e.use_s2 = u2;
        e.ctrl   = tag[13:0];
        return e;
    endfunction

    function automatic in_t mi(bit empty, logic [95:0] d, bit rdy, bit frz, bit misp, bit flc,
                               bit wbv, int wbr);
        in_t r;
        r.empty = empty; r.data = d; r.ready = rdy; r.frz = frz;
        r.misp = misp; r.flc = flc; r.wbv = wbv; r.wbr = wbr[4:0];
        return r;
    endfunction

    function automatic vec_t v(bit empty, logic [95:0] d, bit rdy, bit frz, bit misp, bit flc,
                               bit wbv, int wbr, bit erd, bit eval);
        vec_t r;
        r.in = mi(empty, d, rdy, frz, misp, flc, wbv, wbr);
        r.e_rd = erd;
        r.e_val = eval;
        return r;
    endfunction

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // A register counts as busy unless this cycle's writeback retires it.
    function automatic bit busy_eff(logic [4:0] idx, in_t in);
        return (idx != 0) && m_busy[idx] && !(in.wbv && in.wbr == idx);
    endfunction

    function automatic bit m_hazard(in_t in);
        entry_t e;
        e = m_data;
        return (e.use_s1 && busy_eff(e.src1, in)) || (e.use_s2 && busy_eff(e.src2, in)) ||
               (e.wr_en && busy_eff(e.dst, in));
    endfunction

    task automatic model_reset();
        m_hold = 0;
        m_data = '0;
        foreach (m_busy[i]) m_busy[i] = 0;
        m_issued = 0;
        m_stalls = 0;
    endtask

    task automatic drive(in_t in);
        bus.empty_FIFO = in.empty;
        bus.data_out   = in.data;
        bus.ex_ready   = in.ready;
        bus.FREEZE     = in.frz;
        bus.mispredict = in.misp;
        bus.flush_fCOM = in.flc;
        bus.wb_valid   = in.wbv;
        bus.wb_reg     = in.wbr;
    endtask

    task automatic cycle(input in_t in, input bit use_tab, input bit t_rd, input bit t_val,
                         output bit popped);
        bit     e_val, e_rd, fire;
        entry_t e;
        @(negedge CLK);
        drive(in);
        #1;
        e_val = m_hold && !m_hazard(in) && !in.frz && !in.misp && !in.flc;
        fire  = e_val && in.ready;
        e_rd  = !in.frz && !in.misp && !in.flc && !in.empty && (!m_hold || fire);
        chk("do_read", bus.do_read, e_rd);
        chk("ex_valid", bus.ex_valid, e_val);
        chk("ex_data", bus.ex_data, m_data);
        if (use_tab) begin
            chk("tab_do_read", bus.do_read, t_rd);
            chk("tab_ex_valid", bus.ex_valid, t_val);
        end
`ifdef ID_ISSUE_STATS_EN
        chk("stat_issued", bus.stat_issued, m_issued);
        chk("stat_stalls", bus.stat_stalls, m_stalls);
`endif
        e = m_data;
        if (fire) m_issued++;
        if (m_hold && !fire && !in.frz) m_stalls++;
        if (in.wbv) m_busy[in.wbr] = 0;
        if (fire && e.wr_en && e.dst != 0) m_busy[e.dst] = 1;
        if (in.misp || in.flc) m_hold = 0;
        else if (e_rd) begin
            m_hold = 1;
            m_data = in.data;
        end else if (fire) m_hold = 0;
        popped = e_rd;
        @(posedge CLK);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [95:0] z, d;
        logic [95:0] fifo[$];
        bit          p;
        in_t         in;

        z = '0;
        RESET = 1'b1;
        drive(mi(0, mk(1, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0));
        #2;
        chk("reset_do_read", bus.do_read, 0);
        chk("reset_ex_valid", bus.ex_valid, 0);
        chk("reset_ex_data", bus.ex_data, 0);
`ifdef ID_ISSUE_STATS_EN
        chk("reset_stat_issued", bus.stat_issued, 0);
        chk("reset_stat_stalls", bus.stat_stalls, 0);
`endif
        bus.empty_FIFO = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();

        // RAW on r3, released by a same-cycle writeback
        vecs.push_back(v(0, mk(3, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, mk(4, 3, 0, 1, 1, 0), 1, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 1, 3, 0, 1));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 0));
        // set/clear race on r7: set wins
        vecs.push_back(v(0, mk(7, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 1, 7, 0, 1));
        vecs.push_back(v(0, mk(9, 7, 0, 0, 1, 0), 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 1, 7, 0, 1));
        // mispredict / commit flush leave r5 busy
        vecs.push_back(v(0, mk(5, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, mk(6, 0, 5, 0, 0, 1), 1, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(v(0, mk(10, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, mk(0, 5, 0, 0, 1, 0), 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, mk(11, 0, 0, 0, 0, 0), 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 1, 5, 0, 0));
        // backpressure 3 cycles; held entry writes r0
        vecs.push_back(v(0, mk(0, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0, 1, 0));
        d = mk(12, 0, 0, 0, 0, 0);
        repeat (3) vecs.push_back(v(0, d, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 1));
        // freeze 2 cycles; r0 dst again must not hazard
        vecs.push_back(v(0, mk(0, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0, 1, 0));
        d = mk(13, 0, 0, 0, 0, 0);
        repeat (2) vecs.push_back(v(0, d, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, d, 1, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 0));
        // back-to-back independent entries
        vecs.push_back(v(0, mk(16, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 17; i < 20; i++) begin
            vecs.push_back(v(0, mk(i, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0, 1, 1));
        end
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, z, 1, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) cycle(vecs[i].in, 1, vecs[i].e_rd, vecs[i].e_val, p);

        // reset while holding a stalled entry with r8 busy
        cycle(mi(0, mk(8, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0), 1, 1, 0, p);
        cycle(mi(0, mk(21, 8, 0, 0, 1, 0), 1, 0, 0, 0, 0, 0), 1, 1, 1, p);
        cycle(mi(1, z, 0, 0, 0, 0, 0, 0), 1, 0, 0, p);
        @(negedge CLK);
        bus.empty_FIFO = 1'b0;
        RESET = 1'b1;
        #1;
        chk("rst_mid_do_read", bus.do_read, 0);
        chk("rst_mid_ex_valid", bus.ex_valid, 0);
        chk("rst_mid_ex_data", bus.ex_data, 0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        bus.empty_FIFO = 1'b1;
        RESET = 1'b0;
        cycle(mi(0, mk(22, 8, 0, 0, 1, 0), 1, 0, 0, 0, 0, 0), 1, 1, 0, p);
        cycle(mi(1, z, 1, 0, 0, 0, 0, 0), 1, 0, 1, p);

        for (int n = 0; n < 600; n++) begin
            if (fifo.size() < 4 && $urandom_range(0, 99) < 60) begin
                fifo.push_back(mk($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1))));
            end
            in.empty = (fifo.size() == 0);
            in.data  = in.empty ? {$urandom(), $urandom(), $urandom()} : fifo[0];
            in.ready = ($urandom_range(0, 99) < 75);
            in.frz   = ($urandom_range(0, 99) < 8);
            in.misp  = ($urandom_range(0, 99) < 3);
            in.flc   = ($urandom_range(0, 99) < 2);
            in.wbv   = ($urandom_range(0, 99) < 40);
            in.wbr   = 5'($urandom_range(0, 6));
            cycle(in, 0, 0, 0, p);
            if (p) void'(fifo.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
